// File: rtl/sdram_arbiter.sv
// SDRAM bus arbiter: passes the init sequencer through after reset, then grants
// the SDRAM pins to one of refresh / write / read at a time (refresh > write > read).
module sdram_arbiter #(
   parameter logic [3:0] CMD_NOP = 4'b0111,
   parameter int         ADDR_W  = 13,
   parameter int         BA_W    = 2
) (
   input  logic              sysclk_100M,
   input  logic              rst_n,
   input  logic [3:0]        init_cmd,
   input  logic [BA_W-1:0]   init_ba,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic              init_end,
   input  logic              refresh_req,
   input  logic              refresh_end,
   input  logic [3:0]        refresh_cmd,
   output logic              refresh_ack,
   input  logic              wr_req,
   input  logic              wr_end,
   input  logic [3:0]        wr_cmd,
   input  logic [BA_W-1:0]   wr_ba,
   input  logic [ADDR_W-1:0] wr_addr,
   output logic              wr_ack,
   input  logic              rd_req,
   input  logic              rd_end,
   input  logic [3:0]        rd_cmd,
   input  logic [BA_W-1:0]   rd_ba,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic              sdram_cke,
   output logic [3:0]        sdram_cmd,
   output logic [BA_W-1:0]   sdram_ba,
   output logic [ADDR_W-1:0] sdram_addr
);

   typedef enum logic [2:0] {
      INIT  = 3'd0,
      ARBIT = 3'd1,
      AREF  = 3'd2,
      WRITE = 3'd3,
      READ  = 3'd4
   } state_t;

   state_t state, state_next;

   // State register; asynchronous reset returns to the init pass-through
   always_ff @(posedge sysclk_100M or negedge rst_n) begin
      if (!rst_n) state <= INIT;
      else        state <= state_next;
   end

   // Next state: fixed-priority grant from ARBIT, each service runs to its own end
   always_comb begin
      state_next = state;
      case (state)
         INIT:  if (init_end) state_next = ARBIT;
         ARBIT: begin
            if      (refresh_req) state_next = AREF;
            else if (wr_req)      state_next = WRITE;
            else if (rd_req)      state_next = READ;
         end
         AREF:  if (refresh_end) state_next = ARBIT;
         WRITE: if (wr_end)      state_next = ARBIT;
         READ:  if (rd_end)      state_next = ARBIT;
         default: state_next = INIT;
      endcase
   end

   // Bus mux: combinational on registered state, no added latency from master to pins
   always_comb begin
      sdram_cmd  = CMD_NOP;
      sdram_ba   = '0;
      sdram_addr = '0;
      case (state)
         INIT: begin
            sdram_cmd  = init_cmd;
            sdram_ba   = init_ba;
            sdram_addr = init_addr;
         end
         AREF: sdram_cmd = refresh_cmd;
         WRITE: begin
            sdram_cmd  = wr_cmd;
            sdram_ba   = wr_ba;
            sdram_addr = wr_addr;
         end
         READ: begin
            sdram_cmd  = rd_cmd;
            sdram_ba   = rd_ba;
            sdram_addr = rd_addr;
         end
         default: ;
      endcase
   end

   assign refresh_ack = (state == AREF);
   assign wr_ack      = (state == WRITE);
   assign rd_ack      = (state == READ);
   assign sdram_cke   = 1'b1;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Testbench for sdram_arbiter: per-cycle vector table plus hand-written
// sequences for pre-emption and asynchronous reset during a read.
module tb_sdram_arbiter;

   localparam logic [3:0]  NOP     = 4'b0111;
   localparam logic [3:0]  I_CMD   = 4'b0010;
   localparam logic [1:0]  I_BA    = 2'b01;
   localparam logic [12:0] I_ADDR  = 13'h0400;
   localparam logic [3:0]  W_CMD   = 4'b0100;
   localparam logic [1:0]  W_BA    = 2'b01;
   localparam logic [12:0] W_ADDR  = 13'h0123;
   localparam logic [3:0]  R_CMD   = 4'b0101;
   localparam logic [1:0]  R_BA    = 2'b10;
   localparam logic [12:0] R_ADDR  = 13'h1ABC;
   localparam logic [3:0]  REF_ACT = 4'b0001;

   typedef enum {T_INIT, T_NOP, T_REF, T_WR, T_RD} tag_t;

   typedef struct {
      logic       ie, rq, re, wq, we, dq, de;
      logic [3:0] rcmd;
      tag_t       tag;
   } vec_t;

   typedef struct {
      logic [2:0]  ack;
      logic [3:0]  cmd;
      logic [1:0]  ba;
      logic [12:0] addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  init_cmd, refresh_cmd, wr_cmd, rd_cmd;
   logic [1:0]  init_ba, wr_ba, rd_ba;
   logic [12:0] init_addr, wr_addr, rd_addr;
   logic        init_end, refresh_req, refresh_end, wr_req, wr_end, rd_req, rd_end;
   logic        refresh_ack, wr_ack, rd_ack, sdram_cke;
   logic [3:0]  sdram_cmd;
   logic [1:0]  sdram_ba;
   logic [12:0] sdram_addr;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   sdram_arbiter #(.CMD_NOP(4'b0111), .ADDR_W(13), .BA_W(2)) dut (
      .sysclk_100M(clk), .rst_n(rst_n),
      .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr), .init_end(init_end),
      .refresh_req(refresh_req), .refresh_end(refresh_end), .refresh_cmd(refresh_cmd),
      .refresh_ack(refresh_ack),
      .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
      .wr_ack(wr_ack),
      .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
      .rd_ack(rd_ack),
      .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr)
   );

   function automatic vec_t mk(logic ie, logic rq, logic re, logic wq, logic we,
                               logic dq, logic de, logic [3:0] rcmd, tag_t tag);
      vec_t v;
      v.ie = ie; v.rq = rq; v.re = re; v.wq = wq; v.we = we;
      v.dq = dq; v.de = de; v.rcmd = rcmd; v.tag = tag;
      return v;
   endfunction

   // Expected pins for the owner named by the tag
   function automatic exp_t expand(tag_t tag, logic [3:0] rcmd);
      exp_t e;
      case (tag)
         T_INIT:  begin e.ack = 3'b000; e.cmd = I_CMD; e.ba = I_BA;  e.addr = I_ADDR; end
         T_REF:   begin e.ack = 3'b100; e.cmd = rcmd;  e.ba = 2'b00; e.addr = 13'h0;  end
         T_WR:    begin e.ack = 3'b010; e.cmd = W_CMD; e.ba = W_BA;  e.addr = W_ADDR; end
         T_RD:    begin e.ack = 3'b001; e.cmd = R_CMD; e.ba = R_BA;  e.addr = R_ADDR; end
         default: begin e.ack = 3'b000; e.cmd = NOP;   e.ba = 2'b00; e.addr = 13'h0;  end
      endcase
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, compare pins 1ns later
   task automatic step(input string name, input vec_t v);
      exp_t e;
      @(negedge clk);
      init_end = v.ie; refresh_req = v.rq; refresh_end = v.re; refresh_cmd = v.rcmd;
      wr_req = v.wq; wr_end = v.we; rd_req = v.dq; rd_end = v.de;
      sb.push_back(expand(v.tag, v.rcmd));
      #1;
      e = sb.pop_front();
      check({name, " acks"}, {29'd0, refresh_ack, wr_ack, rd_ack}, {29'd0, e.ack});
      check({name, " bus"}, {13'd0, sdram_cmd, sdram_ba, sdram_addr}, {13'd0, e.cmd, e.ba, e.addr});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      init_cmd = I_CMD; init_ba = I_BA; init_addr = I_ADDR;
      wr_cmd = W_CMD; wr_ba = W_BA; wr_addr = W_ADDR;
      rd_cmd = R_CMD; rd_ba = R_BA; rd_addr = R_ADDR;
      refresh_cmd = NOP;
      init_end = 0; refresh_req = 0; refresh_end = 0;
      wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;

      // Reset state
      #1;
      check("reset acks", {29'd0, refresh_ack, wr_ack, rd_ack}, 32'd0);
      check("reset cke", {31'd0, sdram_cke}, 32'd1);
      check("reset bus", {13'd0, sdram_cmd, sdram_ba, sdram_addr}, {13'd0, I_CMD, I_BA, I_ADDR});
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      //            ie rq re wq we dq de rcmd     tag
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, NOP,     T_INIT)); // 0 init pass-through
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, NOP,     T_INIT)); // 1 init_end
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, NOP,     T_NOP));  // 2 idle arbit
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, REF_ACT, T_NOP));  // 3 refresh req
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, REF_ACT, T_REF));  // 4 ack 1, cmd routed
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, NOP,     T_REF));  // 5
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, NOP,     T_REF));  // 6
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, NOP,     T_REF));  // 7
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, NOP,     T_REF));  // 8
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, NOP,     T_REF));  // 9
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, NOP,     T_REF));  // 10 ack 7, refresh_end
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, NOP,     T_NOP));  // 11 stale refresh_end
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, NOP,     T_NOP));  // 12 stale wr/rd end
      tbl.push_back(mk(0, 1, 0, 1, 0, 1, 0, REF_ACT, T_NOP));  // 13 collision
      tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, REF_ACT, T_REF));  // 14 wr_end ignored
      tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, NOP,     T_REF));  // 15
      tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, NOP,     T_REF));  // 16
      tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, NOP,     T_REF));  // 17 refresh end
      tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, NOP,     T_NOP));  // 18 write wins
      tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, NOP,     T_WR));   // 19 refresh_end ignored
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, NOP,     T_WR));   // 20
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, NOP,     T_WR));   // 21
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, NOP,     T_WR));   // 22 write end
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, NOP,     T_NOP));  // 23 read wins
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, NOP,     T_RD));   // 24
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, NOP,     T_RD));   // 25
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, NOP,     T_RD));   // 26
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, NOP,     T_RD));   // 27 read end
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, NOP,     T_NOP));  // 28
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, NOP,     T_WR));   // 29 one-cycle write, req held
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, NOP,     T_NOP));  // 30 back-to-back regrant
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, NOP,     T_WR));   // 31
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, NOP,     T_NOP));  // 32

      foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

      // Refresh arriving mid-write waits for wr_end plus one ARBIT cycle
      step("nopre arbit", mk(0, 0, 0, 1, 0, 0, 0, REF_ACT, T_NOP));
      for (int i = 1; i <= 10; i++)
         step($sformatf("nopre wr%0d", i),
              mk(0, (i >= 3), 0, 0, (i == 10), 0, 0, REF_ACT, T_WR));
      step("nopre gap", mk(0, 1, 0, 0, 0, 0, 0, REF_ACT, T_NOP));
      step("nopre ref", mk(0, 0, 0, 0, 0, 0, 0, REF_ACT, T_REF));
      step("nopre refend", mk(0, 0, 1, 0, 0, 0, 0, REF_ACT, T_REF));
      step("nopre idle", mk(0, 0, 0, 0, 0, 0, 0, NOP, T_NOP));

      // Asynchronous reset while a read is granted
      step("rst rdreq", mk(0, 0, 0, 0, 0, 1, 0, NOP, T_NOP));
      step("rst rdack", mk(0, 0, 0, 0, 0, 0, 0, NOP, T_RD));
      #2 rst_n = 1'b0;
      #1;
      check("rst async acks", {29'd0, refresh_ack, wr_ack, rd_ack}, 32'd0);
      check("rst async bus", {13'd0, sdram_cmd, sdram_ba, sdram_addr}, {13'd0, I_CMD, I_BA, I_ADDR});
      @(posedge clk);
      #2 rst_n = 1'b1;
      step("rst rdend1", mk(0, 0, 0, 0, 0, 1, 1, NOP, T_INIT));
      step("rst rdend2", mk(0, 0, 0, 0, 0, 1, 1, NOP, T_INIT));
      step("rst initend", mk(1, 0, 0, 0, 0, 1, 0, NOP, T_INIT));
      step("rst arbit", mk(0, 0, 0, 0, 0, 1, 0, NOP, T_NOP));
      step("rst regrant", mk(0, 0, 0, 0, 0, 0, 0, NOP, T_RD));
      step("rst rdend3", mk(0, 0, 0, 0, 0, 0, 1, NOP, T_RD));
      step("rst final", mk(0, 0, 0, 0, 0, 0, 0, NOP, T_NOP));

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
